// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the
// pipeline registers, forwarding unit and write-back stage.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB inputs, decode read ports and write-back outputs of
// the write-back stage, bundled as one interface.
interface wb_regfile_stage_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
);

    logic [DATA_W-1:0] wb_alu_data;
    logic [DATA_W-1:0] wb_mem_data;
    logic [ADDR_W-1:0] wb_rd_address;
    logic              wb_RegWrite;
    logic              wb_MemtoReg;
    logic [ADDR_W-1:0] rs1_address;
    logic [ADDR_W-1:0] rs2_address;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_commit;
    logic [31:0]       commit_count;

    modport master (
        output wb_alu_data, wb_mem_data, wb_rd_address,
        output wb_RegWrite, wb_MemtoReg,
        output rs1_address, rs2_address,
        input  rs1_data, rs2_data, wb_data,
        input  wb_commit, commit_count
    );

    modport slave (
        input  wb_alu_data, wb_mem_data, wb_rd_address,
        input  wb_RegWrite, wb_MemtoReg,
        input  rs1_address, rs2_address,
        output rs1_data, rs2_data, wb_data,
        output wb_commit, commit_count
    );

endinterface

// File: rtl/regfile_core.sv
// Architectural register file: one write port, two read ports
// with same-cycle write-through bypass; x0 reads as zero.
module regfile_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // wr_en never targets x0, so the three arms are disjoint
    always_comb begin
        rs1_data = '0;
        unique case (1'b1)
            (rs1_addr == '0):
                rs1_data = '0;
            (wr_en && rs1_addr == wr_addr):
                rs1_data = wr_data;
            default:
                rs1_data = regs[rs1_addr];
        endcase
    end

    always_comb begin
        rs2_data = '0;
        unique case (1'b1)
            (rs2_addr == '0):
                rs2_data = '0;
            (wr_en && rs2_addr == wr_addr):
                rs2_data = wr_data;
            default:
                rs2_data = regs[rs2_addr];
        endcase
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: result select, commit decode, register file
// and committed-write counter.
module wb_regfile_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic               clk,
    input  logic               reset,
    wb_regfile_stage_if.slave  bus
);

    logic [DATA_W-1:0] wb_data;
    logic              wr_en;
    logic              commit_q;
    logic [31:0]       count_q;

    assign wb_data = bus.wb_MemtoReg ? bus.wb_mem_data
                                     : bus.wb_alu_data;

    // Gating on reset keeps bypass off while held in reset
    assign wr_en = bus.wb_RegWrite
                && (bus.wb_rd_address != '0)
                && reset;

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (bus.wb_rd_address),
        .wr_data  (wb_data),
        .rs1_addr (bus.rs1_address),
        .rs2_addr (bus.rs2_address),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_q <= 1'b0;
            count_q  <= '0;
        end else begin
            commit_q <= wr_en;
            if (wr_en) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign bus.wb_data      = wb_data;
    assign bus.wb_commit    = commit_q;
    assign bus.commit_count = count_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: mux, commit, bypass,
// x0 discard, async reset and counter wrap.
module tb_wb_regfile_stage;
    import cpu_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    wb_regfile_stage_if bus ();

    wb_regfile_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic drive(input logic we,
                         input reg_addr_t rd,
                         input logic m2r,
                         input word_t alu,
                         input word_t mem);
        bus.wb_RegWrite   = we;
        bus.wb_rd_address = rd;
        bus.wb_MemtoReg   = m2r;
        bus.wb_alu_data   = alu;
        bus.wb_mem_data   = mem;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drive(1'b0, 5'd0, 1'b0, '0, '0);
        bus.rs1_address = 5'd5;
        bus.rs2_address = 5'd3;
        step();
        step();
        chk("rst_rs1", bus.rs1_data, 32'h0);
        chk("rst_rs2", bus.rs2_data, 32'h0);
        chk("rst_commit", {31'b0, bus.wb_commit}, 32'h0);
        chk("rst_count", bus.commit_count, 32'h0);
        reset = 1'b1;
        step();

        // ALU result select and commit
        drive(1'b1, 5'd3, 1'b0, 32'hAAAA0001, 32'h5555);
        #1;
        chk("mux_alu", bus.wb_data, 32'hAAAA0001);
        step();
        drive(1'b0, 5'd3, 1'b0, '0, '0);
        bus.rs1_address = 5'd3;
        #1;
        chk("rd_x3_alu", bus.rs1_data, 32'hAAAA0001);
        chk("commit_1", {31'b0, bus.wb_commit}, 32'h1);
        chk("count_1", bus.commit_count, 32'd1);
        step();
        chk("commit_pulse", {31'b0, bus.wb_commit}, 32'h0);
        chk("count_hold", bus.commit_count, 32'd1);

        // Load data select
        drive(1'b1, 5'd3, 1'b1, 32'hAAAA0001, 32'h5555);
        #1;
        chk("mux_mem", bus.wb_data, 32'h5555);
        step();
        drive(1'b0, 5'd0, 1'b0, '0, '0);
        #1;
        chk("rd_x3_mem", bus.rs1_data, 32'h5555);
        chk("count_2", bus.commit_count, 32'd2);

        // Same-cycle bypass on both ports
        bus.rs1_address = 5'd7;
        bus.rs2_address = 5'd7;
        drive(1'b1, 5'd7, 1'b0, 32'hDEADBEEF, 32'h0);
        #1;
        chk("byp_rs1", bus.rs1_data, 32'hDEADBEEF);
        chk("byp_rs2", bus.rs2_data, 32'hDEADBEEF);
        step();
        drive(1'b0, 5'd0, 1'b0, '0, '0);
        #1;
        chk("stored_x7", bus.rs2_data, 32'hDEADBEEF);
        chk("count_3", bus.commit_count, 32'd3);

        // Writes to x0 are dropped
        bus.rs1_address = 5'd0;
        drive(1'b1, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h0);
        #1;
        chk("x0_wbdata", bus.wb_data, 32'hFFFFFFFF);
        chk("x0_rs1", bus.rs1_data, 32'h0);
        step();
        chk("x0_commit", {31'b0, bus.wb_commit}, 32'h0);
        chk("x0_count", bus.commit_count, 32'd3);

        // RegWrite low: no bypass, no write
        bus.rs1_address = 5'd4;
        drive(1'b0, 5'd4, 1'b0, 32'h99, 32'h0);
        #1;
        chk("nowr_byp", bus.rs1_data, 32'h0);
        step();
        chk("nowr_x4", bus.rs1_data, 32'h0);
        chk("nowr_commit", {31'b0, bus.wb_commit}, 32'h0);
        chk("nowr_count", bus.commit_count, 32'd3);

        // Async reset mid-cycle after writing x5
        bus.rs1_address = 5'd5;
        bus.rs2_address = 5'd3;
        drive(1'b1, 5'd5, 1'b0, 32'h1234, 32'h0);
        step();
        drive(1'b0, 5'd0, 1'b0, '0, '0);
        #1;
        chk("x5_pre", bus.rs1_data, 32'h1234);
        chk("commit_pre", {31'b0, bus.wb_commit}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_x5", bus.rs1_data, 32'h0);
        chk("arst_x3", bus.rs2_data, 32'h0);
        chk("arst_count", bus.commit_count, 32'h0);
        chk("arst_commit", {31'b0, bus.wb_commit}, 32'h0);
        drive(1'b1, 5'd5, 1'b0, 32'h77, 32'h0);
        #1;
        chk("arst_nobyp", bus.rs1_data, 32'h0);
        step();
        chk("arst_hold", bus.rs1_data, 32'h0);

        // First edge out of reset commits
        bus.rs1_address = 5'd6;
        drive(1'b1, 5'd6, 1'b0, 32'h66, 32'h0);
        reset = 1'b1;
        step();
        drive(1'b0, 5'd0, 1'b0, '0, '0);
        #1;
        chk("post_rst_x6", bus.rs1_data, 32'h66);
        chk("post_rst_cnt", bus.commit_count, 32'd1);

        // Counter wrap via backdoor preload
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        #1;
        chk("cnt_preload", bus.commit_count, 32'hFFFFFFFF);
        drive(1'b1, 5'd9, 1'b0, 32'h1, 32'h0);
        step();
        drive(1'b0, 5'd0, 1'b0, '0, '0);
        #1;
        chk("cnt_wrap", bus.commit_count, 32'h0);
        chk("wrap_commit", {31'b0, bus.wb_commit}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile_stage.md
# wb_regfile_stage

Write-back stage and architectural register file for the pipelined processor. It consumes the MEM/WB pipeline register outputs and selects the write-back value (ALU result or load data). It commits that value into a 32-entry register file and serves the two decode-stage read ports with same-cycle write-through bypass. It also exposes the write-back value for EX-stage forwarding and keeps a committed-write counter for debug and performance.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width
- NREGS, 32, number of architectural registers (2**ADDR_W); entry 0 is hardwired zero

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- wb_alu_data  in  DATA_W  ALU result from MEM/WB
- wb_mem_data  in  DATA_W  load data from MEM/WB
- wb_rd_address  in  ADDR_W  destination register from MEM/WB
- wb_RegWrite  in  1  write enable from MEM/WB
- wb_MemtoReg  in  1  1 = write load data, 0 = write ALU result
- rs1_address  in  ADDR_W  decode read port 1 address
- rs2_address  in  ADDR_W  decode read port 2 address
- rs1_data  out  DATA_W  read port 1 data (combinational)
- rs2_data  out  DATA_W  read port 2 data (combinational)
- wb_data  out  DATA_W  selected write-back value (combinational), to forwarding unit
- wb_commit  out  1  registered pulse: a non-x0 write committed on the previous edge
- commit_count  out  32  number of committed non-x0 writes since reset

## Operation
- wb_data = wb_MemtoReg ? wb_mem_data : wb_alu_data. Independent of wb_RegWrite.
- Write condition: wr_en = wb_RegWrite && (wb_rd_address != 0) && reset high.
- On the edge with wr_en, regs[wb_rd_address] <= wb_data.
- Writes to x0 are discarded. They do not pulse wb_commit and do not count.
- Read port n, evaluated in priority order:
  - address 0 -> 0
  - wr_en && address == wb_rd_address -> wb_data (bypass)
  - otherwise regs[address]
- Both ports may bypass in the same cycle. Both ports may read the same address.
- commit_count increments by 1 on each edge with wr_en and wraps from 0xFFFFFFFF to 0.
- wb_commit <= wr_en each edge.
- Reset low, asynchronous:
  - all regs cleared to 0
  - commit_count = 0
  - wb_commit = 0
  - bypass disabled; reads return stored values, which are 0
- Reset deasserting mid-stream: the first edge with reset high may commit a write.

## Timing
- Write latency: 1 edge from a valid MEM/WB entry to the value appearing in storage.
- Read-after-write in the same cycle: 0 cycles via bypass, so decode sees the new value combinationally.
- wb_data and rs*_data are combinational from inputs.
- wb_commit and commit_count lag wr_en by exactly 1 edge.
- Reset values: rs1_data = rs2_data = 0, wb_commit = 0, commit_count = 0. wb_data follows its inputs.
- No stall or handshake. One write per cycle, accepted unconditionally.

## Structure
- Shared package (cpu_pkg): DATA_W, ADDR_W, NREGS constants, and the reg_addr_t / word_t typedefs, shared with the pipeline registers and forwarding unit.
- Sub-module regfile_core holds the storage array, the write port and both bypassed read ports.
- Top level holds the write-back mux, the wr_en decode, the commit counter and the wb_commit flop.

## Test plan
- Reset: assert reset low mid-run after writing x5 = 0x1234 -> rs1_data(x5) = 0 immediately, commit_count = 0, wb_commit = 0.
- Mux and write:
  - Stimulus: RegWrite=1, rd=3, MemtoReg=0, alu=0xAAAA0001, mem=0x5555; next cycle read x3.
  - Required: wb_data = 0xAAAA0001; read returns 0xAAAA0001; wb_commit = 1 for one cycle; count = 1.
  - Repeat with MemtoReg=1 -> 0x5555 stored.
- Bypass: rs1 = rs2 = 7 while writing x7 = 0xDEADBEEF -> both read ports show 0xDEADBEEF in the same cycle, before the edge.
- x0: RegWrite=1, rd=0, data 0xFFFFFFFF -> rs1_data(x0) = 0, no bypass, wb_commit = 0, count unchanged.
- RegWrite=0 with rd=4 and data 0x99 -> x4 unchanged, read port not bypassed, count unchanged.
- Counter wrap: force 2^32-1 commits (or preload via backdoor) then one more write -> commit_count = 0.
